// File: rtl/cpm_arb_pkg.sv
// Shared types and the rotating-priority pick used by every destination of cpm_arb_xbar.
package cpm_arb_pkg;

  localparam int REQ_NUM_DEF = 8;
  localparam int DST_NUM_DEF = 4;

  // Largest REQ_NUM rr_pick can scan; index fields are sized to it.
  localparam int RR_MAX = 64;
  localparam int RR_IW  = $clog2(RR_MAX);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_st_e;

  typedef struct packed {
    lock_st_e         lock;
    logic [RR_IW-1:0] own;
    logic [RR_IW-1:0] ptr;
  } dst_state_t;

  typedef struct packed {
    logic             found;
    logic [RR_IW-1:0] idx;
  } rr_pick_t;

  // First set bit of cand (below n) after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(
    input logic [RR_MAX-1:0] cand,
    input logic [RR_IW-1:0]  ptr,
    input logic [RR_IW:0]    n
  );
    rr_pick_t         res;
    logic [RR_IW:0]   pos;
    res = '0;
    for (int off = 1; off <= RR_MAX; off++) begin
      pos = {1'b0, ptr} + (RR_IW+1)'(off);
      if (pos >= n) pos = pos - n;
      if (!res.found && ((RR_IW+1)'(off) <= n) && cand[pos[RR_IW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[RR_IW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cpm_arb_rr_dst.sv
// One destination: candidate filter, round-robin pick, and the burst lock FSM
// (burst lock built only when CPM_ARB_BURST_LOCK_EN is defined).
module cpm_arb_rr_dst
  import cpm_arb_pkg::*;
#(
  parameter int REQ_NUM = REQ_NUM_DEF,
  parameter int DST_NUM = DST_NUM_DEF,
  parameter int DST_ID  = 0,
  parameter int REQ_AW  = $clog2(REQ_NUM),
  parameter int DST_AW  = $clog2(DST_NUM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REQ_NUM-1:0]            req_vld,
  input  logic [REQ_NUM-1:0][DST_AW-1:0] req_dst,
  input  logic [REQ_NUM-1:0]            req_last,
  input  logic [REQ_NUM-1:0]            blocked,
  input  logic                          rdy,
  output logic                          vld,
  output logic [REQ_AW-1:0]             sel,
  output logic [REQ_NUM-1:0]            gnt,
  output dst_state_t                    state
);

  // Handshake: a beat moves when vld && rdy; gnt of the selected requester
  // asserts in that same cycle and the state commits on the next clk edge.

  logic [REQ_NUM-1:0] hit;
  logic [RR_MAX-1:0]  cand;
  rr_pick_t           pick;
  dst_state_t         st_q, st_d;
  logic [RR_IW-1:0]   sel_q, sel_full;
  logic               owner_vld, xfer;

  always_comb begin
    hit  = '0;
    cand = '0;
    for (int r = 0; r < REQ_NUM; r++) begin
      hit[r]  = req_vld[r] && (req_dst[r] == DST_AW'(DST_ID));
      cand[r] = hit[r] && !blocked[r];
    end
  end

  assign pick = rr_pick(cand, st_q.ptr, (RR_IW+1)'(REQ_NUM));

  // Output process: the owner alone is eligible while locked.
  always_comb begin
    owner_vld = 1'b0;
    for (int r = 0; r < REQ_NUM; r++) begin
      if (st_q.own == RR_IW'(r)) owner_vld = hit[r];
    end
    if (st_q.lock == ST_LOCKED) begin
      vld      = owner_vld;
      sel_full = st_q.own;
    end else begin
      vld      = pick.found;
      sel_full = pick.found ? pick.idx : sel_q;
    end
    xfer = vld && rdy;
    sel  = '0;
    gnt  = '0;
    for (int r = 0; r < REQ_NUM; r++) begin
      if (sel_full == RR_IW'(r)) begin
        sel    = REQ_AW'(r);
        gnt[r] = xfer;
      end
    end
  end

`ifdef CPM_ARB_BURST_LOCK_EN
  logic last_beat;

  always_comb begin
    last_beat = 1'b0;
    for (int r = 0; r < REQ_NUM; r++) begin
      if (sel_full == RR_IW'(r)) last_beat = req_last[r];
    end
    st_d = st_q;
    if (xfer) begin
      if (last_beat) begin
        st_d.lock = ST_UNLOCKED;
        st_d.ptr  = sel_full;
      end else if (st_q.lock == ST_UNLOCKED) begin
        st_d.lock = ST_LOCKED;
        st_d.own  = sel_full;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;

  // Every beat counts as last: lock and owner stay at their reset values.
  always_comb begin
    st_d      = st_q;
    st_d.lock = ST_UNLOCKED;
    st_d.own  = '0;
    if (xfer) st_d.ptr = sel_full;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q.lock <= ST_UNLOCKED;
      st_q.own  <= '0;
      st_q.ptr  <= RR_IW'(REQ_NUM - 1);
      sel_q     <= '0;
    end else begin
      st_q  <= st_d;
      sel_q <= sel_full;
    end
  end

  assign state = st_q;

endmodule

// File: rtl/cpm_arb_xbar.sv
// REQ_NUM x DST_NUM round-robin arbiter with optional burst lock (CPM_ARB_BURST_LOCK_EN);
// drives per-destination mux selects and per-requester grants.
module cpm_arb_xbar
  import cpm_arb_pkg::*;
#(
  parameter int REQ_NUM = REQ_NUM_DEF,
  parameter int DST_NUM = DST_NUM_DEF,
  parameter int REQ_AW  = $clog2(REQ_NUM),
  parameter int DST_AW  = $clog2(DST_NUM)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [REQ_NUM-1:0]             req_vld,
  input  logic [REQ_NUM-1:0][DST_AW-1:0] req_dst,
  input  logic [REQ_NUM-1:0]             req_last,
  input  logic [DST_NUM-1:0]             dst_rdy,
  output logic [REQ_NUM-1:0]             gnt,
  output logic [DST_NUM-1:0]             dst_vld,
  output logic [DST_NUM-1:0][REQ_AW-1:0] dst_sel
);

  dst_state_t [DST_NUM-1:0]              st;
  logic [DST_NUM-1:0][REQ_NUM-1:0]       held, blocked, dgnt;
  logic [REQ_NUM-1:0]                    held_any;
  logic                                  unused_ptr;

  // A requester owning a lock on one destination may not compete on any other.
  always_comb begin
    held       = '0;
    held_any   = '0;
    blocked    = '0;
    unused_ptr = 1'b0;
    for (int d = 0; d < DST_NUM; d++) begin
      for (int r = 0; r < REQ_NUM; r++) begin
        held[d][r] = (st[d].lock == ST_LOCKED) && (st[d].own == RR_IW'(r));
      end
      held_any   = held_any | held[d];
      unused_ptr = unused_ptr ^ (^st[d].ptr);
    end
    for (int d = 0; d < DST_NUM; d++) begin
      blocked[d] = held_any & ~held[d];
    end
  end

  for (genvar d = 0; d < DST_NUM; d++) begin : g_dst
    cpm_arb_rr_dst #(
      .REQ_NUM (REQ_NUM),
      .DST_NUM (DST_NUM),
      .DST_ID  (d),
      .REQ_AW  (REQ_AW),
      .DST_AW  (DST_AW)
    ) u_dst (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_vld  (req_vld),
      .req_dst  (req_dst),
      .req_last (req_last),
      .blocked  (blocked[d]),
      .rdy      (dst_rdy[d]),
      .vld      (dst_vld[d]),
      .sel      (dst_sel[d]),
      .gnt      (dgnt[d]),
      .state    (st[d])
    );
  end

  always_comb begin
    gnt = '0;
    for (int d = 0; d < DST_NUM; d++) gnt = gnt | dgnt[d];
  end

endmodule

// File: doc/cpm_arb_xbar.md
# cpm_arb_xbar

Parametrised multi-requester, multi-destination arbiter for the CPM datapath. It generalises the fixed 4-way index arbiter to REQ_NUM requesters and DST_NUM destinations. Each destination runs its own round-robin pointer, and a granted multi-beat burst stays locked to its requester until the last beat. The block sits between the PE request ports and the shared SRAM-bank/accumulator ports and drives the per-destination mux selects.

## Interface
- REQ_NUM, 8, number of requesters
- DST_NUM, 4, number of destinations
- REQ_AW, $clog2(REQ_NUM), requester index width
- DST_AW, $clog2(DST_NUM), destination index width
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- req_vld  in  REQ_NUM  per-requester beat valid
- req_dst  in  REQ_NUM x DST_AW  target destination of each requester
- req_last  in  REQ_NUM  beat is the last of its burst
- dst_rdy  in  DST_NUM  destination accepts a beat this cycle
- gnt  out  REQ_NUM  beat of requester r transferred this cycle
- dst_vld  out  DST_NUM  destination d has a selected valid beat
- dst_sel  out  DST_NUM x REQ_AW  requester selected for destination d

## Operation
- Per-destination state:
  - lock_d (1 b)
  - own_d (REQ_AW)
  - ptr_d (REQ_AW), the last served requester
- Candidate set for d: C_d = {r : req_vld[r] && req_dst[r]==d && r not locked on another destination}.
- req_dst values of DST_NUM or above (non-power-of-two DST_NUM) are never candidates. Such a requester is never granted.
- **State UNLOCKED** (lock_d=0):
  - Winner w is the first r in C_d scanning ptr_d+1, ptr_d+2, … modulo REQ_NUM.
  - dst_vld[d]=|C_d and dst_sel[d]=w. dst_sel holds its previous registered value when C_d is empty.
- **State LOCKED** (lock_d=1):
  - Only own_d is eligible: dst_vld[d]=req_vld[own_d] && req_dst[own_d]==d, and dst_sel[d]=own_d.
  - All other requesters to d are stalled, including when the owner's valid is low.
- Transfer on d: dst_vld[d] && dst_rdy[d]. It asserts gnt[dst_sel[d]] in the same cycle.
- Transfer with req_last=1:
  - lock_d<=0 and ptr_d<=dst_sel[d].
  - The next winner is the requester after it, so fairness is per burst, not per beat.
- Transfer with req_last=0 from UNLOCKED: lock_d<=1 and own_d<=dst_sel[d]. ptr_d is unchanged.
- No transfer: state unchanged.
- Requester protocol:
  - Hold req_dst and the beat stable until gnt.
  - Keep req_dst constant for a whole burst.
  - If the owner changes req_dst mid-burst, that is a protocol violation. d stays locked, and the owner cannot compete elsewhere.
- A requester is granted on at most one destination per cycle by construction. gnt is one-hot per requester.

## Timing
- Arbitration is combinational, 0 cycles: gnt, dst_vld and dst_sel depend on req_* and dst_rdy in the same cycle.
- lock_d, own_d and ptr_d update on the posedge of clk after a transfer. A release on the last beat lets a new winner be granted in the next cycle with no bubble.
- Reset values:
  - lock_d=0, own_d=0, ptr_d=REQ_NUM-1, so requester 0 has first priority.
  - dst_vld=0, gnt=0 and dst_sel=0 while inputs are idle.
- Reset mid-burst aborts every lock immediately. No pending state is retained.
- Last beat plus a new request from another requester in the same cycle: the new requester is evaluated next cycle against the updated ptr_d.
- Single-beat burst (req_last=1 on the first beat): the destination never enters LOCKED.

## Configuration
- CPM_ARB_BURST_LOCK_EN defined: burst locking as above.
- Undefined:
  - req_last is ignored and every transfer is treated as last.
  - Round-robin re-arbitrates per beat and lock_d/own_d are not built.
  - dst_vld therefore never stalls behind an idle owner.

## Structure
- Package cpm_arb_pkg holds:
  - default REQ_NUM/DST_NUM
  - the rr_pick function (masked rotate + priority find returning index and found flag)
  - the per-destination state struct (lock, own, ptr).
- Sub-module cpm_arb_rr_dst implements one destination's candidate filtering, pick and state registers. It is instantiated DST_NUM times in a generate loop.
- The top level ORs the per-destination grants into gnt and computes the "locked elsewhere" mask per requester.

## Test plan
- After reset, req_vld=8'hFF, all req_dst=0, req_last=1, dst_rdy[0]=1 -> gnt one-hot cycling 0,1,…,7,0, one per cycle.
- Requester 2 sends a burst of 3 beats to d1 (last on the 3rd) while requester 5 also targets d1 -> gnt[2] for 3 transfers, then gnt[5]. dst_sel[1] stays 2 during owner valid gaps and dst_vld[1]=0 in the gaps.
- Requesters 0,1,2,3 target d0,d1,d2,d3 concurrently, all dst_rdy=1 -> gnt=8'h0F in a single cycle.
- dst_rdy[2]=0 for 4 cycles with requester 6 targeting d2 -> dst_vld[2]=1, gnt[6]=0; on the rdy rise gnt[6]=1 the same cycle.
- rst_n pulsed low during a locked burst on d3 by requester 4, with requester 1 also waiting on d3 -> after release, requester 1 wins (ptr reset to 7, so 1 comes before 4).
- With CPM_ARB_BURST_LOCK_EN undefined, bursts of req_last=0 from requesters 2 and 5 to d1 -> grants alternate 2,5,2,5.
